// File: rtl/usb_sie_tx_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : usb_sie_tx_if
// Description : Bundle between the SIE transmit packetizer and its neighbours:
//               packet request/status, payload byte stream and the UTMI
//               transmit port. The "slave" modport is the packetizer side;
//               the "master" modport is the surrounding logic.
// Revision    : 1.0 - initial release
// ============================================================================
interface usb_sie_tx_if;
    // packet request / status
    logic       pkt_start;
    logic [3:0] pkt_pid;
    logic       pkt_has_data;
    logic       pkt_zlp;
    logic       pkt_busy;
    logic       pkt_done;
    logic       pkt_err;
    // payload byte stream
    logic [7:0] pld_data;
    logic       pld_valid;
    logic       pld_last;
    logic       pld_ready;
    // UTMI transmit side
    logic [7:0] utmi_data_out;
    logic       utmi_tx_valid;
    logic       utmi_tx_ready;

    modport master (
        output pkt_start, pkt_pid, pkt_has_data, pkt_zlp,
        output pld_data, pld_valid, pld_last,
        output utmi_tx_ready,
        input  pkt_busy, pkt_done, pkt_err, pld_ready,
        input  utmi_data_out, utmi_tx_valid
    );

    modport slave (
        input  pkt_start, pkt_pid, pkt_has_data, pkt_zlp,
        input  pld_data, pld_valid, pld_last,
        input  utmi_tx_ready,
        output pkt_busy, pkt_done, pkt_err, pld_ready,
        output utmi_data_out, utmi_tx_valid
    );
endinterface
`default_nettype wire

// File: rtl/usb_sie_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : usb_sie_tx
// Description : USB SIE transmit packetizer. Emits PID, forwards payload
//               bytes from a valid/ready stream, appends CRC16 (low byte
//               first) for data packets, then holds an inter-packet gap.
//               utmi_data_out always holds the byte currently presented; a
//               new byte is loaded only on a cycle where utmi_tx_ready=1.
// Revision    : 1.0 - initial release
// ============================================================================
module usb_sie_tx #(
    parameter int GAP_CYCLES  = 16,
    parameter int MAX_PAYLOAD = 1023
) (
    input  logic        clk,
    input  logic        rst_n,
    usb_sie_tx_if.slave bus
);

    localparam int              GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [9:0]      CNT_MAX  = 10'(MAX_PAYLOAD);

    // State names describe what utmi_data_out is presenting (GAP: nothing).
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PID    = 3'd1,
        S_DATA   = 3'd2,
        S_CRC_LO = 3'd3,
        S_CRC_HI = 3'd4,
        S_GAP    = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic             has_data_q, has_data_d;
    logic             zlp_q, zlp_d;
    logic             last_q, last_d;      // presented payload byte is the last one
    logic [9:0]       cnt_q, cnt_d;
    logic [15:0]      crc_q, crc_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [15:0]      crc_next;
    logic             want_byte;
    logic             overlen;
    logic             take;

    // Reflected CRC16 (poly 0x8005 -> 0xA001), one byte LSB-first.
    function automatic logic [15:0] crc16_upd(input logic [15:0] crc, input logic [7:0] d);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ d[i]) c = (c >> 1) ^ 16'hA001;
            else             c = c >> 1;
        end
        return c;
    endfunction

    // Payload acceptance: a byte is consumed only when the UTM takes the
    // current byte, the next byte must come from the stream, and the
    // packet has not already reached its maximum length.
    always_comb begin
        crc_next  = crc16_upd(crc_q, bus.pld_data);
        want_byte = ((state_q == S_PID) && has_data_q && !zlp_q) ||
                    ((state_q == S_DATA) && !last_q);
        overlen   = (cnt_q == CNT_MAX);
        take      = bus.utmi_tx_ready && want_byte && bus.pld_valid && !overlen;
    end

    // Next-state and output-register logic.
    always_comb begin
        state_d    = state_q;
        has_data_d = has_data_q;
        zlp_d      = zlp_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        crc_d      = crc_q;
        gap_d      = gap_q;
        data_d     = data_q;
        valid_d    = valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.pkt_start) begin
                    has_data_d = bus.pkt_has_data;
                    zlp_d      = bus.pkt_zlp;
                    last_d     = 1'b0;
                    cnt_d      = 10'd0;
                    crc_d      = 16'hFFFF;
                    data_d     = {~bus.pkt_pid, bus.pkt_pid};
                    valid_d    = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = S_PID;
                end
            end
            S_PID, S_DATA: begin
                if (bus.utmi_tx_ready) begin
                    if (!want_byte) begin
                        if ((state_q == S_PID) && !has_data_q) begin
                            // handshake packet complete
                            valid_d = 1'b0;
                            data_d  = 8'h00;
                            gap_d   = '0;
                            done_d  = 1'b1;
                            state_d = S_GAP;
                        end else begin
                            // zero-length payload or last payload byte taken
                            data_d  = ~crc_q[7:0];
                            state_d = S_CRC_LO;
                        end
                    end else if (take) begin
                        data_d  = bus.pld_data;
                        crc_d   = crc_next;
                        cnt_d   = cnt_q + 10'd1;
                        last_d  = bus.pld_last;
                        state_d = S_DATA;
                    end else begin
                        // underrun or overlength: truncate, UTM ends with EOP
                        valid_d = 1'b0;
                        data_d  = 8'h00;
                        gap_d   = '0;
                        err_d   = 1'b1;
                        state_d = S_GAP;
                    end
                end
            end
            S_CRC_LO: begin
                if (bus.utmi_tx_ready) begin
                    data_d  = ~crc_q[15:8];
                    state_d = S_CRC_HI;
                end
            end
            S_CRC_HI: begin
                if (bus.utmi_tx_ready) begin
                    valid_d = 1'b0;
                    data_d  = 8'h00;
                    gap_d   = '0;
                    done_d  = 1'b1;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
                data_d  = 8'h00;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            has_data_q <= 1'b0;
            zlp_q      <= 1'b0;
            last_q     <= 1'b0;
            cnt_q      <= 10'd0;
            crc_q      <= 16'hFFFF;
            gap_q      <= '0;
            data_q     <= 8'h00;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            has_data_q <= has_data_d;
            zlp_q      <= zlp_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            crc_q      <= crc_d;
            gap_q      <= gap_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus.pld_ready     = take;
    assign bus.utmi_data_out = data_q;
    assign bus.utmi_tx_valid = valid_q;
    assign bus.pkt_busy      = busy_q;
    assign bus.pkt_done      = done_q;
    assign bus.pkt_err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_usb_sie_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_usb_sie_tx
// Description : Directed self-checking bench for usb_sie_tx. Inputs change
//               on the falling edge; outputs are sampled 1ns later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_sie_tx;

    localparam int GAP = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    usb_sie_tx_if bus ();
    usb_sie_tx_if bus2 ();

    usb_sie_tx #(.GAP_CYCLES(GAP), .MAX_PAYLOAD(1023)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    usb_sie_tx #(.GAP_CYCLES(GAP), .MAX_PAYLOAD(4)) dut_ml (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] payload [9];
    logic [7:0] got [$];
    int         n_ready, n_done, n_err, n_unstable, n_busy_gap_low;
    logic       busy_after_gap;

    task automatic idle_inputs();
        bus.pkt_start = 1'b0; bus.pkt_pid = 4'h0; bus.pkt_has_data = 1'b0; bus.pkt_zlp = 1'b0;
        bus.pld_data = 8'h00; bus.pld_valid = 1'b0; bus.pld_last = 1'b0; bus.utmi_tx_ready = 1'b0;
        bus2.pkt_start = 1'b0; bus2.pkt_pid = 4'h0; bus2.pkt_has_data = 1'b0; bus2.pkt_zlp = 1'b0;
        bus2.pld_data = 8'h00; bus2.pld_valid = 1'b0; bus2.pld_last = 1'b0; bus2.utmi_tx_ready = 1'b0;
    endtask

    // Wait for the DUT to be free, then pulse pkt_start for one clock.
    task automatic start_pkt(input logic [3:0] pid, input logic hd, input logic zlp);
        int w = 0;
        while (bus.pkt_busy && w < 200) begin @(negedge clk); w++; end
        if (w >= 200) begin
            checks++; errors++;
            $display("FAIL start_wait: pkt_busy still %0b after %0d cycles, required 0", bus.pkt_busy, w);
        end
        bus.pkt_start = 1'b1; bus.pkt_pid = pid; bus.pkt_has_data = hd; bus.pkt_zlp = zlp;
        @(negedge clk);
        bus.pkt_start = 1'b0;
    endtask

    // Drive one packet's payload/tx_ready and record what the UTM side sees,
    // through the end of the gap. drop_at>=0 withholds bytes from that index.
    task automatic run_pkt(input int n, input int drop_at, input int period);
        int idx = 0;
        int c   = 0;
        int k   = -1;
        logic pv = 1'b0, pr = 1'b0;
        logic [7:0] pd = 8'h00;
        got.delete();
        n_ready = 0; n_done = 0; n_err = 0; n_unstable = 0; n_busy_gap_low = 0;
        busy_after_gap = 1'b1;
        while (c < 600) begin
            bus.utmi_tx_ready = ((c % period) == period - 1);
            bus.pld_valid     = (idx < n) && !(drop_at >= 0 && idx >= drop_at);
            bus.pld_data      = (idx < n) ? payload[idx] : 8'h00;
            bus.pld_last      = (n > 0) && (idx == n - 1);
            #1;
            if (bus.utmi_tx_valid && pv && !pr && (bus.utmi_data_out !== pd)) n_unstable++;
            if (bus.utmi_tx_valid && bus.utmi_tx_ready) got.push_back(bus.utmi_data_out);
            if (bus.pld_ready) begin n_ready++; idx++; end
            if (bus.pkt_done) n_done++;
            if (bus.pkt_err)  n_err++;
            if (k < 0 && !bus.utmi_tx_valid) k = 0;
            if (k >= 0) begin
                if (k < GAP && !bus.pkt_busy) n_busy_gap_low++;
                if (k == GAP) begin
                    busy_after_gap = bus.pkt_busy;
                    break;
                end
                k++;
            end
            pv = bus.utmi_tx_valid; pr = bus.utmi_tx_ready; pd = bus.utmi_data_out;
            @(negedge clk);
            c++;
        end
        if (c >= 600) begin
            checks++; errors++;
            $display("FAIL run_timeout: packet not finished after %0d cycles", c);
        end
        bus.utmi_tx_ready = 1'b0; bus.pld_valid = 1'b0; bus.pld_last = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.pld_valid = 1'b1; bus.utmi_tx_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (bus.utmi_tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %0b, required 0", bus.utmi_tx_valid); end
        checks++; if (bus.utmi_data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out: got %02h, required 00", bus.utmi_data_out); end
        checks++; if (bus.pkt_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b, required 0", bus.pkt_busy); end
        checks++; if (bus.pkt_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b, required 0", bus.pkt_done); end
        checks++; if (bus.pkt_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b, required 0", bus.pkt_err); end
        checks++; if (bus.pld_ready !== 1'b0) begin errors++; $display("FAIL reset_pld_ready: got %0b, required 0", bus.pld_ready); end
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ack();
        start_pkt(4'b0010, 1'b0, 1'b0);
        run_pkt(0, -1, 4);
        checks++; if (got.size() !== 1) begin errors++; $display("FAIL ack_len: got %0d bytes, required 1", got.size()); end
        checks++; if (got.size() < 1 || got[0] !== 8'hD2) begin errors++; $display("FAIL ack_byte: got %02h, required D2", (got.size() > 0) ? got[0] : 8'hxx); end
        checks++; if (n_done !== 1) begin errors++; $display("FAIL ack_done: got %0d pulses, required 1", n_done); end
        checks++; if (n_err !== 0) begin errors++; $display("FAIL ack_err: got %0d pulses, required 0", n_err); end
        checks++; if (n_busy_gap_low !== 0) begin errors++; $display("FAIL ack_busy_gap: busy low %0d gap cycles, required 0", n_busy_gap_low); end
        checks++; if (busy_after_gap !== 1'b0) begin errors++; $display("FAIL ack_busy_end: got %0b, required 0", busy_after_gap); end
    endtask

    // Hold pkt_start from the moment tx_valid falls; it must only be taken
    // once the gap has elapsed.
    task automatic test_gap();
        int w = 0;
        int zeros = 0;
        start_pkt(4'b0010, 1'b0, 1'b0);
        bus.utmi_tx_ready = 1'b1;
        while (bus.utmi_tx_valid && w < 50) begin @(negedge clk); w++; end
        bus.pkt_start = 1'b1; bus.pkt_pid = 4'b0010; bus.pkt_has_data = 1'b0; bus.pkt_zlp = 1'b0;
        while (!bus.utmi_tx_valid && zeros < 100) begin zeros++; @(negedge clk); end
        bus.pkt_start = 1'b0;
        checks++; if (zeros !== GAP + 1) begin errors++; $display("FAIL gap_len: tx_valid low %0d clocks, required %0d", zeros, GAP + 1); end
        run_pkt(0, -1, 1);
        checks++; if (got.size() !== 1 || got[0] !== 8'hD2) begin errors++; $display("FAIL gap_next_pkt: got %0d bytes first %02h, required 1 byte D2", got.size(), (got.size() > 0) ? got[0] : 8'hxx); end
    endtask

    task automatic test_zlp();
        logic [7:0] exp [3] = '{8'hC3, 8'h00, 8'h00};
        start_pkt(4'b0011, 1'b1, 1'b1);
        run_pkt(0, -1, 2);
        checks++; if (got.size() !== 3) begin errors++; $display("FAIL zlp_len: got %0d bytes, required 3", got.size()); end
        for (int i = 0; i < 3; i++) begin
            logic [7:0] g;
            g = (i < got.size()) ? got[i] : 8'hxx;
            checks++; if (g !== exp[i]) begin errors++; $display("FAIL zlp_byte%0d: got %02h, required %02h", i, g, exp[i]); end
        end
        checks++; if (n_done !== 1) begin errors++; $display("FAIL zlp_done: got %0d pulses, required 1", n_done); end
        checks++; if (n_ready !== 0) begin errors++; $display("FAIL zlp_pld_ready: got %0d pulses, required 0", n_ready); end
    endtask

    task automatic test_data1(input int period);
        logic [7:0] exp [12] = '{8'h4B, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
                                 8'h36, 8'h37, 8'h38, 8'h39, 8'hC8, 8'hB4};
        start_pkt(4'b1011, 1'b1, 1'b0);
        run_pkt(9, -1, period);
        checks++; if (got.size() !== 12) begin errors++; $display("FAIL data1_len(p%0d): got %0d bytes, required 12", period, got.size()); end
        for (int i = 0; i < 12; i++) begin
            logic [7:0] g;
            g = (i < got.size()) ? got[i] : 8'hxx;
            checks++; if (g !== exp[i]) begin errors++; $display("FAIL data1_byte%0d(p%0d): got %02h, required %02h", i, period, g, exp[i]); end
        end
        checks++; if (n_ready !== 9) begin errors++; $display("FAIL data1_pld_ready(p%0d): got %0d pulses, required 9", period, n_ready); end
        checks++; if (n_done !== 1 || n_err !== 0) begin errors++; $display("FAIL data1_status(p%0d): done %0d err %0d, required 1 0", period, n_done, n_err); end
        checks++; if (n_unstable !== 0) begin errors++; $display("FAIL data1_hold(p%0d): %0d changes while stalled, required 0", period, n_unstable); end
    endtask

    task automatic test_underrun();
        logic [7:0] exp [5] = '{8'h4B, 8'h31, 8'h32, 8'h33, 8'h34};
        start_pkt(4'b1011, 1'b1, 1'b0);
        run_pkt(9, 4, 1);
        checks++; if (got.size() !== 5) begin errors++; $display("FAIL under_len: got %0d bytes, required 5", got.size()); end
        for (int i = 0; i < 5; i++) begin
            logic [7:0] g;
            g = (i < got.size()) ? got[i] : 8'hxx;
            checks++; if (g !== exp[i]) begin errors++; $display("FAIL under_byte%0d: got %02h, required %02h", i, g, exp[i]); end
        end
        checks++; if (n_err !== 1) begin errors++; $display("FAIL under_err: got %0d pulses, required 1", n_err); end
        checks++; if (n_done !== 0) begin errors++; $display("FAIL under_done: got %0d pulses, required 0", n_done); end
        checks++; if (n_ready !== 4) begin errors++; $display("FAIL under_pld_ready: got %0d pulses, required 4", n_ready); end
        checks++; if (n_busy_gap_low !== 0 || busy_after_gap !== 1'b0) begin errors++; $display("FAIL under_busy: low-in-gap %0d end %0b, required 0 0", n_busy_gap_low, busy_after_gap); end
    endtask

    // MAX_PAYLOAD=4 instance fed a 5-byte payload.
    task automatic test_overlen();
        logic [7:0] exp [5] = '{8'hC3, 8'h11, 8'h12, 8'h13, 8'h14};
        logic [7:0] got2 [$];
        int idx = 0, c = 0, nd = 0, ne = 0;
        bus2.pkt_start = 1'b1; bus2.pkt_pid = 4'b0011; bus2.pkt_has_data = 1'b1; bus2.pkt_zlp = 1'b0;
        @(negedge clk);
        bus2.pkt_start = 1'b0;
        while (c < 60) begin
            bus2.utmi_tx_ready = 1'b1;
            bus2.pld_valid     = (idx < 5);
            bus2.pld_data      = 8'(17 + idx);
            bus2.pld_last      = (idx == 4);
            #1;
            if (bus2.utmi_tx_valid && bus2.utmi_tx_ready) got2.push_back(bus2.utmi_data_out);
            if (bus2.pld_ready) idx++;
            if (bus2.pkt_done) nd++;
            if (bus2.pkt_err) ne++;
            if (!bus2.utmi_tx_valid) break;
            @(negedge clk);
            c++;
        end
        idle_inputs();
        checks++; if (c >= 60) begin errors++; $display("FAIL over_timeout: tx_valid still high after %0d cycles", c); end
        checks++; if (got2.size() !== 5) begin errors++; $display("FAIL over_len: got %0d bytes, required 5", got2.size()); end
        for (int i = 0; i < 5; i++) begin
            logic [7:0] g;
            g = (i < got2.size()) ? got2[i] : 8'hxx;
            checks++; if (g !== exp[i]) begin errors++; $display("FAIL over_byte%0d: got %02h, required %02h", i, g, exp[i]); end
        end
        checks++; if (idx !== 4) begin errors++; $display("FAIL over_consumed: got %0d bytes consumed, required 4", idx); end
        checks++; if (ne !== 1 || nd !== 0) begin errors++; $display("FAIL over_status: err %0d done %0d, required 1 0", ne, nd); end
        repeat (GAP + 2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        start_pkt(4'b1011, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            bus.utmi_tx_ready = 1'b1; bus.pld_valid = 1'b1; bus.pld_data = payload[i]; bus.pld_last = 1'b0;
            @(negedge clk);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.utmi_tx_valid !== 1'b0 || bus.utmi_data_out !== 8'h00) begin errors++; $display("FAIL rstmid_utmi: valid %0b data %02h, required 0 00", bus.utmi_tx_valid, bus.utmi_data_out); end
        checks++; if (bus.pkt_busy !== 1'b0 || bus.pkt_done !== 1'b0 || bus.pkt_err !== 1'b0) begin errors++; $display("FAIL rstmid_status: busy %0b done %0b err %0b, required 0 0 0", bus.pkt_busy, bus.pkt_done, bus.pkt_err); end
        checks++; if (bus.pld_ready !== 1'b0) begin errors++; $display("FAIL rstmid_pld_ready: got %0b, required 0", bus.pld_ready); end
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_pkt(4'b1010, 1'b0, 1'b0);
        #1;
        checks++; if (bus.utmi_tx_valid !== 1'b1 || bus.utmi_data_out !== 8'h5A) begin errors++; $display("FAIL rstmid_nak_first: valid %0b data %02h, required 1 5A", bus.utmi_tx_valid, bus.utmi_data_out); end
        run_pkt(0, -1, 1);
        checks++; if (got.size() !== 1 || got[0] !== 8'h5A || n_done !== 1) begin errors++; $display("FAIL rstmid_nak_pkt: %0d bytes first %02h done %0d, required 1 5A 1", got.size(), (got.size() > 0) ? got[0] : 8'hxx, n_done); end
    endtask

    initial begin
        for (int i = 0; i < 9; i++) payload[i] = 8'(8'h31 + i);
        idle_inputs();
        rst_n = 1'b0;
        test_reset();
        test_ack();
        test_gap();
        test_zlp();
        test_data1(1);
        test_data1(3);
        test_underrun();
        test_overlen();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
`default_nettype wire
